// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_param -- shared parameters for the P5 fetch path.
//
// Contents:
//   PC_RESET  byte address of the first instruction (IM word 0)
//   IM_DEPTH  number of 32-bit instruction-memory words
//   IDX_W     IM word-index width, clog2(IM_DEPTH)
//   IM_BYTES  byte span of the instruction memory
//   fetch_state_e  fetch sequencer states BOOT / RUN / FAULT
// ---------------------------------------------------------------------------
package cpu_param;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          IM_DEPTH = 1024;
    localparam int          IDX_W    = 10;
    localparam logic [31:0] IM_BYTES = 32'(4 * IM_DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_pc_xlate.sv
// ---------------------------------------------------------------------------
// pc_xlate -- byte PC to instruction-memory word index, plus legality.
//
// Ports:
//   pc      in   32     byte address
//   im_idx  out  IDX_W  (pc - PC_RESET) >> 2, truncated
//   legal   out  1      word aligned and inside the IM window
// Purely combinational.
// ---------------------------------------------------------------------------
module pc_xlate
    import cpu_param::*;
(
    input  logic [31:0]      pc,
    output logic [IDX_W-1:0] im_idx,
    output logic             legal
);

    logic [31:0] offset;

    assign offset = pc - PC_RESET;
    assign im_idx = offset[IDX_W+1:2];

    // A pc below PC_RESET wraps to a huge unsigned offset, so a single
    // upper-bound compare covers both ends of the window.
    assign legal = (pc[1:0] == 2'b00) && (offset < IM_BYTES);

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction-fetch sequencer for the P5 pipeline.
//
// Owns the PC, drives the word index to the combinational-read IM and
// captures the returned word into the IF/ID register. Handles hazard
// stalls, D-stage branch/jump redirects and sticky address faults.
//
// Ports:
//   clk             in   1      rising-edge clock
//   reset           in   1      synchronous, active-low reset
//   stall           in   1      freeze PC and IF/ID
//   redirect_valid  in   1      branch/jump taken in D
//   redirect_pc     in   32     target byte address
//   im_idx          out  IDX_W  IM word index, combinational from pc
//   im_rdata        in   32     IM read data, same cycle
//   if_valid        out  1      IF/ID holds a real instruction
//   if_pc           out  32     PC of the IF/ID instruction
//   if_instr        out  32     IF/ID instruction
//   fault           out  1      sticky address fault
//   fetch_cnt       out  32     instructions captured into IF/ID
//
// Build option:
//   FETCH_DELAY_SLOT_EN  when defined, the instruction in IF at a redirect
//                        is kept as a delay slot (captured and counted);
//                        otherwise IF/ID is flushed on a redirect.
// ---------------------------------------------------------------------------
module fetch_ctrl
    import cpu_param::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [IDX_W-1:0] im_idx,
    input  logic [31:0]      im_rdata,
    output logic             if_valid,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_instr,
    output logic             fault,
    output logic [31:0]      fetch_cnt
);

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit KEEP_SLOT = 1'b1;
`else
    localparam bit KEEP_SLOT = 1'b0;
`endif

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  pc_cand;
    logic         cur_legal;
    logic         nxt_legal;

    assign pc_cand = redirect_valid ? redirect_pc : pc + 32'd4;

    pc_xlate u_cur_xlate (
        .pc     (pc),
        .im_idx (im_idx),
        .legal  (cur_legal)
    );

    // Only the legality of the candidate matters; its index is never
    // presented to the IM because an illegal candidate is not loaded.
    pc_xlate u_nxt_xlate (
        .pc     (pc_cand),
        .im_idx (),
        .legal  (nxt_legal)
    );

    // NOTE: every register here is assigned with <= so all of them sample
    // the pre-edge values of pc and state, regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous: it is only seen at a rising edge and
        // takes priority over stall and redirect on that edge.
        if (!reset) begin
            state     <= BOOT;
            pc        <= PC_RESET;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_instr  <= '0;
            fault     <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    // im_idx already points at word 0; give the IM one cycle.
                    state <= RUN;
                end

                RUN: begin
                    if (!stall) begin
                        if (!redirect_valid || KEEP_SLOT) begin
                            if_valid  <= 1'b1;
                            if_pc     <= pc;
                            if_instr  <= im_rdata;
                            fetch_cnt <= fetch_cnt + 32'd1;
                        end else begin
                            // Flush: if_pc/if_instr keep their stale contents.
                            if_valid <= 1'b0;
                        end

                        // cur_legal is always true in practice; it guards
                        // against ever indexing the IM from a bad pc.
                        if (nxt_legal && cur_legal) begin
                            pc <= pc_cand;
                        end else begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end
                end

                FAULT: begin
                    if_valid <= 1'b0;
                    fault    <= 1'b1;
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl.
//
// A behavioural model tracks what the fetch path must hold after every
// edge; a compare process checks all outputs against it on each falling
// edge. A directed section pins the model with hand-computed literals,
// then a randomized section mixes stalls, redirects, faults and resets.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
    import cpu_param::*;

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [IDX_W-1:0] im_idx;
    logic [31:0]      im_rdata;
    logic             if_valid;
    logic [31:0]      if_pc;
    logic [31:0]      if_instr;
    logic             fault;
    logic [31:0]      fetch_cnt;

    logic [31:0] mem [0:IM_DEPTH-1];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign im_rdata = mem[im_idx];

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_idx         (im_idx),
        .im_rdata       (im_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .fault          (fault),
        .fetch_cnt      (fetch_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_started = 1'b0;
    bit          m_booting;
    bit          m_faulted;
    logic [31:0] m_pc;
    bit          m_ifvalid;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifinstr;
    logic [31:0] m_cnt;

    function automatic bit pc_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h0000_3000) && (a < 32'h0000_3000 + 32'd4096);
    endfunction

    always @(posedge clk) begin
        logic [31:0] nxt;
        if (!reset) begin
            m_started = 1'b1;
            m_booting = 1'b1;
            m_faulted = 1'b0;
            m_pc      = 32'h0000_3000;
            m_ifvalid = 1'b0;
            m_ifpc    = 32'd0;
            m_ifinstr = 32'd0;
            m_cnt     = 32'd0;
        end else if (m_started) begin
            if (m_booting) begin
                m_booting = 1'b0;
            end else if (m_faulted) begin
                m_ifvalid = 1'b0;
            end else if (!stall) begin
                nxt = redirect_valid ? redirect_pc : m_pc + 32'd4;
                if (!redirect_valid || DS) begin
                    m_ifvalid = 1'b1;
                    m_ifpc    = m_pc;
                    m_ifinstr = mem[(m_pc - 32'h0000_3000) / 4];
                    m_cnt     = m_cnt + 32'd1;
                end else begin
                    m_ifvalid = 1'b0;
                end
                if (pc_ok(nxt)) m_pc = nxt;
                else m_faulted = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("m.if_valid", 32'(if_valid), 32'(m_ifvalid));
            check("m.if_pc",    if_pc,         m_ifpc);
            check("m.if_instr", if_instr,      m_ifinstr);
            check("m.fault",    32'(fault),    32'(m_faulted));
            check("m.fetch_cnt", fetch_cnt,    m_cnt);
            check("m.im_idx",   32'(im_idx),   (m_pc - 32'h0000_3000) / 4);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    localparam logic [31:0] A = 32'hA0A0_0001;
    localparam logic [31:0] B = 32'hB0B0_0002;
    localparam logic [31:0] C = 32'hC0C0_0003;

    initial begin
        for (int i = 0; i < IM_DEPTH; i++) mem[i] = $urandom;
        mem[0] = A;
        mem[1] = B;
        mem[2] = C;

        reset = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;

        // Reset state.
        cyc(); cyc();
        check("rst.if_valid", 32'(if_valid), 32'd0);
        check("rst.if_pc",    if_pc,         32'd0);
        check("rst.if_instr", if_instr,      32'd0);
        check("rst.fault",    32'(fault),    32'd0);
        check("rst.cnt",      fetch_cnt,     32'd0);
        check("rst.im_idx",   32'(im_idx),   32'd0);

        // BOOT edge: nothing captured.
        reset = 1'b1;
        cyc();
        check("boot.if_valid", 32'(if_valid), 32'd0);
        check("boot.im_idx",   32'(im_idx),   32'd0);

        cyc();
        check("run0.if_pc",    if_pc,    32'h3000);
        check("run0.if_instr", if_instr, A);
        check("run0.cnt",      fetch_cnt, 32'd1);
        cyc();
        check("run1.if_pc",    if_pc,    32'h3004);
        check("run1.if_instr", if_instr, B);
        check("run1.im_idx",   32'(im_idx), 32'd2);

        // Stall three edges with pc at 3008.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall.if_pc",  if_pc,        32'h3004);
            check("stall.im_idx", 32'(im_idx),  32'd2);
            check("stall.cnt",    fetch_cnt,    32'd2);
        end
        stall = 1'b0;
        cyc();
        check("unstall.if_pc",    if_pc,     32'h3008);
        check("unstall.if_instr", if_instr,  C);
        check("unstall.cnt",      fetch_cnt, 32'd3);

        // Redirect from 300C to 3100.
        redirect_valid = 1'b1;
        redirect_pc = 32'h3100;
        cyc();
        redirect_valid = 1'b0;
        check("redir.im_idx",   32'(im_idx),   32'h40);
        check("redir.if_valid", 32'(if_valid), 32'(DS));
        check("redir.if_pc",    if_pc,         DS ? 32'h300C : 32'h3008);
        check("redir.cnt",      fetch_cnt,     DS ? 32'd4 : 32'd3);
        cyc();
        check("tgt.if_pc",    if_pc,     32'h3100);
        check("tgt.if_instr", if_instr,  mem[32'h40]);
        check("tgt.cnt",      fetch_cnt, DS ? 32'd5 : 32'd4);

        // Misaligned redirect from 3104.
        redirect_valid = 1'b1;
        redirect_pc = 32'h3102;
        cyc();
        redirect_valid = 1'b0;
        check("mis.fault",  32'(fault),  32'd1);
        check("mis.im_idx", 32'(im_idx), 32'h41);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("mis.if_valid", 32'(if_valid), 32'd0);
            check("mis.fault",    32'(fault),    32'd1);
            check("mis.im_idx",   32'(im_idx),   32'h41);
        end

        // Fall-through past the last word.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h3FF4;
        cyc();
        redirect_valid = 1'b0;
        cyc(); cyc(); cyc();
        check("end.if_pc",    if_pc,         32'h3FFC);
        check("end.if_instr", if_instr,      mem[IM_DEPTH-1]);
        check("end.if_valid", 32'(if_valid), 32'd1);
        check("end.fault",    32'(fault),    32'd1);
        check("end.im_idx",   32'(im_idx),   32'h3FF);
        check("end.cnt",      fetch_cnt,     DS ? 32'd4 : 32'd3);
        cyc();
        check("end2.if_valid", 32'(if_valid), 32'd0);
        check("end2.if_pc",    if_pc,         32'h3FFC);

        // Reset while stalled with a redirect pending.
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3200;
        reset = 1'b0;
        cyc();
        check("rst2.if_valid", 32'(if_valid), 32'd0);
        check("rst2.if_pc",    if_pc,         32'd0);
        check("rst2.fault",    32'(fault),    32'd0);
        check("rst2.cnt",      fetch_cnt,     32'd0);
        check("rst2.im_idx",   32'(im_idx),   32'd0);
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        cyc();
        check("boot2.if_valid", 32'(if_valid), 32'd0);
        cyc();
        check("resume.if_pc",    if_pc,    32'h3000);
        check("resume.if_instr", if_instr, A);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            stall = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 20);
            case ($urandom_range(0, 19))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'h3000 + 4 * $urandom_range(0, 1023) + 32'd2;
                2:       redirect_pc = 32'h4000;
                3:       redirect_pc = 32'h3FFC;
                default: redirect_pc = 32'h3000 + 4 * $urandom_range(0, 1023);
            endcase
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the P5 pipeline.
- Owns the PC and drives the word index into the combinational-read instruction memory (1024 x 32).
- Captures the returned instruction into the IF/ID register, and applies stall, branch/jump redirect and address-fault handling.
- Sits between the hazard unit / D-stage branch logic and the instruction memory.

Parameters:
- PC_RESET, 32'h0000_3000, byte address of the first instruction; maps to IM word 0.
- IM_DEPTH, 1024, number of IM words.
- IDX_W, 10, IM word-index width; must equal clog2(IM_DEPTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hazard-unit stall; freezes PC and IF/ID.
- redirect_valid  in  1  D-stage branch/jump taken.
- redirect_pc  in  32  target byte address.
- im_idx  out  IDX_W  word index to IM, combinational from PC.
- im_rdata  in  32  instruction word from IM, same cycle.
- if_valid  out  1  IF/ID holds a real instruction.
- if_pc  out  32  PC of the IF/ID instruction.
- if_instr  out  32  IF/ID instruction.
- fault  out  1  sticky address fault.
- fetch_cnt  out  32  count of instructions captured into IF/ID.

Behaviour:
- States: BOOT, RUN, FAULT. Encoding comes from the shared package.
- Reset (reset==0 at a clock edge):
  - state=BOOT, pc=PC_RESET.
  - if_valid=0, if_pc=0, if_instr=0.
  - fault=0, fetch_cnt=0.
  - Reset overrides every other input, including mid-stall and mid-redirect.
- BOOT:
  - Lasts exactly one cycle after reset deasserts, then goes to RUN.
  - No capture; im_idx=0 is already driven.
- Address translation: im_idx = (pc - PC_RESET) >> 2, truncated to IDX_W. It is purely combinational.
- PC legality: a PC is legal when pc[1:0]==0 and PC_RESET <= pc < PC_RESET + 4*IM_DEPTH.
- RUN, stall=1:
  - pc, IF/ID and fetch_cnt all hold.
  - redirect_valid is ignored; the source must hold it until the stall clears.
- RUN, stall=0, redirect_valid=0:
  - IF/ID <= {1, pc, im_rdata}.
  - pc <= pc+4.
  - fetch_cnt += 1, wrapping at 2^32.
- RUN, stall=0, redirect_valid=1:
  - pc <= redirect_pc.
  - The instruction in IF is the delay slot; capture and count follow the optional-feature rules.
- Fault entry, from RUN only, when the next pc (pc+4 or redirect_pc) is illegal:
  - pc stays at its current value.
  - The same-edge capture still happens per the rules above.
  - state <= FAULT.
- FAULT:
  - if_valid <= 0 on the next edge and stays 0; fault=1.
  - pc and fetch_cnt hold.
  - Exited only by reset.
- Sequential fall-through past the last word (pc = PC_RESET+4*IM_DEPTH-4 with no redirect) is a fault, not a wrap.
- Latency: the instruction at a PC appears on if_instr one edge after that PC is presented unstalled.

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- Defined: on a redirect, the delay-slot instruction in IF is captured normally (if_valid=1) and counted. This is MIPS delay-slot semantics.
- Undefined: on a redirect, IF/ID is flushed (if_valid<=0, if_pc/if_instr hold their old values) and fetch_cnt does not increment.

Decomposition:
- Shared package cpu_param:
  - PC_RESET, IM_DEPTH, IDX_W.
  - fetch state encoding: BOOT=2'd0, RUN=2'd1, FAULT=2'd2.
- One sub-module, pc_xlate:
  - Input pc.
  - Outputs im_idx and a legal flag.
  - Instantiated twice: once for the current PC and once for the candidate next PC.

Test Plan:
- Reset then free-run, IM[0..2]=A,B,C:
  - Cycle after BOOT: if_pc=3000/if_instr=A, then 3004/B, then 3008/C.
  - fetch_cnt=3.
- stall=1 for 3 cycles while pc=3008:
  - if_pc stays 3004 and im_idx stays 2 throughout.
  - Next unstalled edge: if_pc=3008, fetch_cnt +1 only.
- redirect_valid=1, redirect_pc=3100, while pc=300C:
  - Next edge: im_idx=0x40.
  - With FETCH_DELAY_SLOT_EN: if_pc=300C, if_valid=1.
  - Without it: if_valid=0.
  - Following edge: if_pc=3100.
- redirect_pc=3102 (misaligned):
  - Next edge: fault=1, state FAULT, pc holds.
  - Following edge: if_valid=0; stays so for 10 cycles.
- Sequential run to pc=3FFC:
  - That instruction is captured and fault=1.
  - No capture from 4000.
- reset=0 asserted mid-stall with redirect_valid=1:
  - All outputs 0, pc=3000.
  - BOOT lasts one cycle, then fetch resumes at 3000.
